// File: rtl/tc_period_meter.sv
// tc_period_meter
// Measures the number of c cycles between consecutive rising edges of the
// upstream terminal-count level and hands each period to a downstream stage
// over a valid/ready report interface.
//
// Build option: define TC_SYNC_EN to pass tc through a 2-flop synchronizer
// before edge detection (upstream counter in another clock domain). This adds
// two cycles of edge-to-report latency.
//
// Ports:
//   c           clock, all state changes on the rising edge
//   start       synchronous active-high reset
//   tc          terminal-count level from the upstream counter
//   enable      1 = measure, 0 = return to IDLE
//   rpt_ready   consumer accepts the report when rpt_valid & rpt_ready
//   rpt_valid   report holding register is full
//   rpt_period  measured period in cycles, stable while rpt_valid = 1
//   rpt_sat     reported period saturated at all-ones
//   overrun     sticky, a measurement was dropped because the report was full
//   busy        FSM is not in IDLE
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | not measuring, per_cnt held at 0
// ARM    | waiting for the first (reference) edge, nothing reported
// MEAS   | counting cycles since the previous edge, report on each edge

module tc_period_meter #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             start,
    input  logic             tc,
    input  logic             enable,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [WIDTH-1:0] rpt_period,
    output logic             rpt_sat,
    output logic             overrun,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic             tc_s;
    logic             tc_d;
    logic             tc_rise;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] per_cnt;
    logic             sat_bit;
    logic             meas_done;
    logic             rpt_load;
    logic             rpt_drop;

`ifdef TC_SYNC_EN
    logic [1:0] tc_sync;

    always_ff @(posedge c) begin
        if (start) begin
            tc_sync <= 2'b00;
        end else begin
            tc_sync <= {tc_sync[0], tc};
        end
    end

    assign tc_s = tc_sync[1];
`else
    assign tc_s = tc;
`endif

    // tc_d tracks tc_s in every state so a level that is already high when
    // measurement starts does not look like a fresh edge.
    always_ff @(posedge c) begin
        if (start) begin
            tc_d <= 1'b0;
        end else begin
            tc_d <= tc_s;
        end
    end

    assign tc_rise = tc_s & ~tc_d;

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_ARM;
                S_ARM:   state_nxt = tc_rise ? S_MEAS : S_ARM;
                S_MEAS:  state_nxt = S_MEAS;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Period counter: restarts at 1 on each edge so that edges at t0 and t1
    // leave exactly t1-t0 in the counter when the second edge arrives.
    always_ff @(posedge c) begin
        if (start || !enable) begin
            per_cnt <= '0;
            sat_bit <= 1'b0;
        end else begin
            case (state)
                S_ARM: begin
                    if (tc_rise) begin
                        per_cnt <= CNT_ONE;
                        sat_bit <= 1'b0;
                    end
                end
                S_MEAS: begin
                    if (tc_rise) begin
                        per_cnt <= CNT_ONE;
                        sat_bit <= 1'b0;
                    end else if (per_cnt != CNT_MAX) begin
                        per_cnt <= per_cnt + CNT_ONE;
                        if (per_cnt == CNT_MAX - CNT_ONE) begin
                            sat_bit <= 1'b1;
                        end
                    end
                end
                default: begin
                    per_cnt <= '0;
                    sat_bit <= 1'b0;
                end
            endcase
        end
    end

    assign meas_done = enable && (state == S_MEAS) && tc_rise;
    // A report being accepted in the same cycle frees the register in time.
    assign rpt_load  = meas_done && (!rpt_valid || rpt_ready);
    assign rpt_drop  = meas_done && rpt_valid && !rpt_ready;

    always_ff @(posedge c) begin
        if (start) begin
            rpt_valid  <= 1'b0;
            rpt_period <= '0;
            rpt_sat    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rpt_load) begin
                rpt_valid  <= 1'b1;
                rpt_period <= per_cnt;
                rpt_sat    <= sat_bit;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
            if (rpt_drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
